i2s_tx: RTL and testbench

//  I2S transmitter clocked by the audio rPLL output. Buffers stereo sample pairs in a small

---
 rtl/audio_pkg.sv | 30 +++
 rtl/sample_fifo.sv | 88 ++++++++
 rtl/i2s_tx.sv | 128 ++++++++++++
 tb/tb_i2s_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg
//   Shared definitions for the audio output path.
//   - AUDIO_DATA_W    : default bits per channel slot
//   - stereo_sample_t : one stereo pair, left in the upper half
//   - I2S_LRCK_*      : word-select levels for the two channels
//   - lrck_for_bit()  : word-select level driven while a given frame bit is on SDATA.
//                       Philips framing switches word select one bit clock ahead of
//                       the MSB of the new channel.
package audio_pkg;

    localparam int AUDIO_DATA_W = 16;

    localparam logic I2S_LRCK_LEFT  = 1'b0;
    localparam logic I2S_LRCK_RIGHT = 1'b1;

    typedef struct packed {
        logic [AUDIO_DATA_W-1:0] left;
        logic [AUDIO_DATA_W-1:0] right;
    } stereo_sample_t;

    // bit_idx counts from 0 (left MSB) to 2*data_w-1 (right LSB).
    // Right-channel select spans bit_idx data_w-1 .. 2*data_w-2.
    function automatic logic lrck_for_bit(input int unsigned bit_idx,
                                          input int unsigned data_w);
        if ((bit_idx >= data_w - 1) && (bit_idx <= 2 * data_w - 2))
            return I2S_LRCK_RIGHT;
        return I2S_LRCK_LEFT;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo
//   Synchronous FIFO for stereo pairs. Push and pop in the same cycle both take
//   effect. A push while full or a pop while empty is ignored. full/empty/count
//   are registered, so nothing downstream sees a combinational path from push/pop.
// Ports
//   clkin      in   1      only clock
//   reset      in   1      asynchronous active-high; empties the FIFO
//   push       in   1      write push_data when not full
//   push_data  in   WIDTH  entry to write
//   pop        in   1      advance the head when not empty
//   pop_data   out  WIDTH  current head entry (show-ahead)
//   full       out  1      count == DEPTH
//   empty      out  1      count == 0
//   count      out  CNT_W  entries held
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             full_reg;
    logic             empty_reg;

    logic push_en;
    logic pop_en;

    assign push_en = push && !full_reg;
    assign pop_en  = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({push_en, pop_en})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clkin) begin
        if (push_en)
            mem[wr_ptr_reg] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_en)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_en)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // The head is needed in the same cycle as the pop that consumes it, so the
    // read is asynchronous; at this depth the array maps to distributed RAM.
    assign pop_data = mem[rd_ptr_reg];
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign count    = count_reg;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx
//   Philips I2S transmitter. Stereo pairs are buffered in a small FIFO and shifted
//   out MSB first with the standard one-bit delay after the word-select edge.
//   BCLK and LRCK run continuously. A frame that starts with the FIFO empty sends
//   zeros and raises underrun for one clkin cycle.
// Ports
//   clkin         in   1       audio clock from the PLL; only clock
//   reset         in   1       asynchronous active-high reset
//   sample_valid  in   1       upstream pair valid
//   sample_ready  out  1       FIFO can accept a pair (registered)
//   sample_left   in   DATA_W  left sample, two's complement
//   sample_right  in   DATA_W  right sample, two's complement
//   i2s_bclk      out  1       bit clock, clkin/(2*BCLK_DIV)
//   i2s_lrck      out  1       word select, 0 = left, 1 = right
//   i2s_sdata     out  1       serial data, changes on BCLK falling edges
//   underrun      out  1       one-cycle pulse: frame started with FIFO empty
module i2s_tx
    import audio_pkg::*;
#(
    parameter int DATA_W     = AUDIO_DATA_W,
    parameter int BCLK_DIV   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] sample_left,
    input  logic [DATA_W-1:0] sample_right,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_sdata,
    output logic              underrun
);

    localparam int FRAME_BITS = 2 * DATA_W;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    logic [DIV_W-1:0]      div_cnt_reg;
    logic                  bclk_reg;
    logic [BIT_W-1:0]      bit_cnt_reg;
    logic [BIT_W-1:0]      bit_cnt_next;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  lrck_reg;
    logic                  sdata_reg;
    logic                  underrun_reg;

    logic                  div_wrap;
    logic                  fall_evt;
    logic                  frame_wrap;
    logic                  frame_load;

    logic                  fifo_push;
    logic [FRAME_BITS-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    // Ready comes from the FIFO's registered full flag, so valid never feeds ready.
    assign sample_ready = !fifo_full;
    assign fifo_push    = sample_valid && sample_ready;

    sample_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkin     (clkin),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({sample_left, sample_right}),
        .pop       (frame_load),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A fall event is the clkin edge on which BCLK toggles from 1 to 0. The serial
    // outputs change on that same edge, so the amplifier samples them on the next
    // rising BCLK edge.
    assign div_wrap     = (div_cnt_reg == DIV_W'(BCLK_DIV - 1));
    assign fall_evt     = div_wrap && bclk_reg;
    assign frame_wrap   = (bit_cnt_reg == BIT_W'(FRAME_BITS - 1));
    assign bit_cnt_next = frame_wrap ? '0 : bit_cnt_reg + BIT_W'(1);
    assign frame_load   = fall_evt && frame_wrap;

    // bit_cnt resets to the last frame bit so that the first fall event after
    // reset wraps it and loads a frame.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            div_cnt_reg  <= '0;
            bclk_reg     <= 1'b0;
            bit_cnt_reg  <= BIT_W'(FRAME_BITS - 1);
            shift_reg    <= '0;
            lrck_reg     <= 1'b0;
            sdata_reg    <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            div_cnt_reg <= div_wrap ? '0 : div_cnt_reg + DIV_W'(1);
            if (div_wrap)
                bclk_reg <= !bclk_reg;

            underrun_reg <= frame_load && (fifo_count == '0);

            if (fall_evt) begin
                bit_cnt_reg <= bit_cnt_next;
                lrck_reg    <= lrck_for_bit(32'(bit_cnt_next), DATA_W);
                if (frame_wrap) begin
                    // The new frame's MSB goes out on this same edge.
                    shift_reg <= fifo_empty ? '0 : fifo_head;
                    sdata_reg <= fifo_empty ? 1'b0 : fifo_head[FRAME_BITS-1];
                end else begin
                    // shift_reg[MSB] is the bit now on the line; present the next one.
                    shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                    sdata_reg <= shift_reg[FRAME_BITS-2];
                end
            end
        end
    end

    assign i2s_bclk  = bclk_reg;
    assign i2s_lrck  = lrck_reg;
    assign i2s_sdata = sdata_reg;
    assign underrun  = underrun_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx
//   Directed bench for i2s_tx with DATA_W=16, BCLK_DIV=2 (BCLK period 4 clkin,
//   frame 128 clkin). A monitor reassembles each 32-bit frame from SDATA/LRCK at
//   BCLK falling edges. The main sequence checks each frame against
//   hand-computed words.
module tb_i2s_tx;
    import audio_pkg::*;

    localparam int DATA_W = 16;

    logic              clkin        = 1'b0;
    logic              reset        = 1'b1;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_left  = '0;
    logic [DATA_W-1:0] sample_right = '0;
    logic              sample_ready;
    logic              i2s_bclk;
    logic              i2s_lrck;
    logic              i2s_sdata;
    logic              underrun;

    i2s_tx #(
        .DATA_W     (DATA_W),
        .BCLK_DIV   (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clkin        (clkin),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .underrun     (underrun)
    );

    always #5 clkin = ~clkin;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor state. It samples 1 time unit after each edge and the main
    // sequence acts 2 units after, so the two never race.
    int          cyc = 0;
    int          bit_k = 0;
    int          last_fall = 0;
    bit          have_fall = 1'b0;
    logic        prev_bclk = 1'b0;
    int          ur_samples = 0;
    int          interval_errs = 0;
    logic [31:0] dbuf, lbuf;
    logic        ubuf;
    logic [31:0] data_q[$];
    logic [31:0] lr_q[$];
    logic        ur_q[$];

    always begin
        @(posedge clkin);
        #1;
        if (reset) begin
            cyc       = 0;
            bit_k     = 0;
            prev_bclk = 1'b0;
            have_fall = 1'b0;
        end else begin
            cyc++;
            if (underrun)
                ur_samples++;
            if (prev_bclk && !i2s_bclk) begin
                if (have_fall && (cyc - last_fall) != 4)
                    interval_errs++;
                have_fall = 1'b1;
                last_fall = cyc;
                dbuf[31 - bit_k] = i2s_sdata;
                lbuf[31 - bit_k] = i2s_lrck;
                if (bit_k == 0)
                    ubuf = underrun;
                if (bit_k == 31) begin
                    data_q.push_back(dbuf);
                    lr_q.push_back(lbuf);
                    ur_q.push_back(ubuf);
                    bit_k = 0;
                end else begin
                    bit_k++;
                end
            end
            prev_bclk = i2s_bclk;
        end
    end

    task automatic tick;
        @(posedge clkin);
        #2;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            tick();
            guard++;
        end
        check("wait_cyc_reached", 32'(cyc >= n), 32'd1);
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r, output int acc_cyc);
        int n = 0;
        sample_valid = 1'b1;
        sample_left  = l;
        sample_right = r;
        while (!sample_ready && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400)
            check("push_timeout", 32'(sample_ready), 32'd1);
        tick();
        acc_cyc      = cyc;
        sample_valid = 1'b0;
    endtask

    function automatic stereo_sample_t pair(input logic [15:0] l, input logic [15:0] r);
        stereo_sample_t s;
        s.left  = l;
        s.right = r;
        return s;
    endfunction

    // LRCK high for bits 15..30 of the frame (MSB-first positions 16..1).
    localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;

    task automatic wait_frame(input string tag, input logic [15:0] l, input logic [15:0] r,
                              input logic exp_ur);
        int n = 0;
        logic [31:0] d, lr;
        logic u;
        stereo_sample_t want;
        while (data_q.size() == 0 && n < 400) begin
            tick();
            n++;
        end
        if (data_q.size() == 0) begin
            check({tag, "_timeout"}, 32'(data_q.size()), 32'd1);
        end else begin
            d    = data_q.pop_front();
            lr   = lr_q.pop_front();
            u    = ur_q.pop_front();
            want = pair(l, r);
            $display("frame %s data=%h lrck=%h underrun=%0d", tag, d, lr, u);
            check({tag, "_data"}, d, 32'(want));
            check({tag, "_lrck"}, lr, LR_PATTERN);
            check({tag, "_underrun"}, 32'(u), 32'(exp_ur));
        end
    endtask

    logic [15:0] pl[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] pr[4] = '{16'h8001, 16'h4002, 16'h2003, 16'h1004};

    initial begin
        int acc;

        // Reset held
        repeat (3) tick();
        check("rst_bclk",     32'(i2s_bclk),     32'd0);
        check("rst_lrck",     32'(i2s_lrck),     32'd0);
        check("rst_sdata",    32'(i2s_sdata),    32'd0);
        check("rst_underrun", 32'(underrun),     32'd0);
        check("rst_ready",    32'(sample_ready), 32'd1);
        reset = 1'b0;

        // First pair pushed before the first fall event (cycle 4)
        push_pair(16'hA5C3, 16'h1234, acc);
        check("push_a_cyc", 32'(acc), 32'd1);
        check("bclk_c1", 32'(i2s_bclk), 32'd0);
        tick();
        check("bclk_c2", 32'(i2s_bclk), 32'd1);

        // Five back-to-back pushes; the fifth waits for the pop at cycle 132
        wait_cyc(10);
        for (int i = 0; i < 4; i++)
            push_pair(pl[i], pr[i], acc);
        check("ready_full", 32'(sample_ready), 32'd0);
        push_pair(16'h5555, 16'h0805, acc);
        check("p5_accept_cyc", 32'(acc), 32'd133);

        wait_frame("f0", 16'hA5C3, 16'h1234, 1'b0);
        for (int i = 0; i < 4; i++)
            wait_frame($sformatf("f%0d", i + 1), pl[i], pr[i], 1'b0);
        wait_frame("f5", 16'h5555, 16'h0805, 1'b0);

        // Frame 6 (load at 772) finds the FIFO empty; the pair pushed later goes to frame 7
        wait_cyc(800);
        push_pair(16'h6666, 16'h0406, acc);
        wait_frame("f6", 16'h0000, 16'h0000, 1'b1);

        // Count 1, then a push on the same edge as the frame-8 pop (cycle 1028)
        wait_cyc(905);
        push_pair(16'h7777, 16'h0207, acc);
        wait_cyc(1027);
        check("ready_cnt1", 32'(sample_ready), 32'd1);
        sample_valid = 1'b1;
        sample_left  = 16'h8888;
        sample_right = 16'h0F0F;
        tick();
        sample_valid = 1'b0;
        push_pair(16'h9999, 16'hCAFE, acc);
        push_pair(16'hAAAA, 16'hBEEF, acc);
        push_pair(16'hBBBB, 16'hF00D, acc);
        check("ready_full2", 32'(sample_ready), 32'd0);

        wait_frame("f7", 16'h6666, 16'h0406, 1'b0);
        wait_frame("f8", 16'h7777, 16'h0207, 1'b0);

        // Frame 9 (8888/0F0F) loaded at 1156; bit 20 is on the line at cycle 1236
        wait_cyc(1236);
        check("sdata_k20", 32'(i2s_sdata), 32'd1);
        check("lrck_k20",  32'(i2s_lrck),  32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_bclk",     32'(i2s_bclk),     32'd0);
        check("mid_rst_lrck",     32'(i2s_lrck),     32'd0);
        check("mid_rst_sdata",    32'(i2s_sdata),    32'd0);
        check("mid_rst_underrun", 32'(underrun),     32'd0);
        check("mid_rst_ready",    32'(sample_ready), 32'd1);
        repeat (3) tick();
        reset = 1'b0;

        // The queued pairs were discarded: both following frames underrun
        wait_frame("post_rst0", 16'h0000, 16'h0000, 1'b1);
        wait_frame("post_rst1", 16'h0000, 16'h0000, 1'b1);

        check("underrun_pulses", 32'(ur_samples),    32'd3);
        check("bclk_intervals",  32'(interval_errs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
